fir_coeffs_loader: RTL and testbench

Writer side of the FIR coefficient store. Accepts a stream of signed 24-bit coefficients over a valid/ready handshake and writes them into the inactive bank of a two-bank coefficient RAM. When a complete set has been received, it switches the active bank exactly on the FIR's `start` pulse, so the coefficient reader never sees a partially loaded set. It sits between the command/control decoder and the coefficient RAM read by the FIR coefficient sequencer.

---
 rtl/fir_coeffs_loader_pkg.sv | 6 +
 rtl/fir_coeffs_loader_if.sv | 13 +
 rtl/fir_coeffs_loader.sv | 140 ++++++++++++++
 tb/tb_fir_coeffs_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coeffs_loader_pkg.sv
// rtl/fir_coeffs_loader_pkg.sv - shared state enum and default sizes for the FIR coefficient loader
package fir_coeffs_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, ARMED} loader_state_t;
  localparam int COEFF_WIDTH_DEF = 24;
  localparam int NUM_COEFFS_DEF  = 256;
endpackage

// File: rtl/fir_coeffs_loader_if.sv
// rtl/fir_coeffs_loader_if.sv - coefficient write stream (valid/ready/data) into the loader
interface fir_coeffs_loader_if
  import fir_coeffs_pkg::*;
#(
  parameter int COEFF_WIDTH = COEFF_WIDTH_DEF
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [COEFF_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/fir_coeffs_loader.sv
// rtl/fir_coeffs_loader.sv - double-buffered coefficient writer, bank swap on start; option FIR_COEFFS_CHECKSUM_EN
module fir_coeffs_loader
  import fir_coeffs_pkg::*;
#(
  parameter int NUM_COEFFS  = NUM_COEFFS_DEF,
  parameter int ADDR_WIDTH  = 8,
  parameter int COEFF_WIDTH = COEFF_WIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load_begin,
  input  logic                    start,
  fir_coeffs_loader_if.slave      wr,
  output logic                    ram_we,
  output logic [ADDR_WIDTH:0]     ram_addr,
  output logic [COEFF_WIDTH-1:0]  ram_wdata,
  output logic                    active_bank,
  output logic                    load_done,
  output logic                    load_error
);

  loader_state_t           state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    ready_q;
  logic                    accept;
`ifdef FIR_COEFFS_CHECKSUM_EN
  logic [COEFF_WIDTH-1:0]  sum;
`endif

  assign wr.wr_ready = ready_q;
  assign accept      = wr.wr_valid & ready_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      ready_q     <= 1'b0;
      active_bank <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
`ifdef FIR_COEFFS_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      ram_we     <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_begin) begin
            state   <= LOAD;
            ready_q <= 1'b1;
            idx     <= '0;
`ifdef FIR_COEFFS_CHECKSUM_EN
            sum     <= '0;
`endif
          end
        end
        LOAD: begin
          if (load_begin) begin
            load_error <= 1'b1;
            idx        <= '0;
`ifdef FIR_COEFFS_CHECKSUM_EN
            sum        <= '0;
`endif
          end else if (accept) begin
            ram_we    <= 1'b1;
            ram_addr  <= {~active_bank, idx};
            ram_wdata <= wr.wr_data;
`ifdef FIR_COEFFS_CHECKSUM_EN
            sum       <= sum + wr.wr_data;
`endif
            // Leave LOAD at the last index so idx never wraps.
            if (idx == ADDR_WIDTH'(NUM_COEFFS - 1)) begin
`ifdef FIR_COEFFS_CHECKSUM_EN
              state   <= CHECK;
`else
              state   <= ARMED;
              ready_q <= 1'b0;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
`ifdef FIR_COEFFS_CHECKSUM_EN
        CHECK: begin
          if (load_begin) begin
            state      <= LOAD;
            load_error <= 1'b1;
            idx        <= '0;
            sum        <= '0;
          end else if (accept) begin
            ready_q <= 1'b0;
            if (wr.wr_data == sum) begin
              state <= ARMED;
            end else begin
              state      <= IDLE;
              load_error <= 1'b1;
            end
          end
        end
`endif
        ARMED: begin
          // A start in the same cycle as load_begin completes the swap before reloading.
          if (start) begin
            active_bank <= ~active_bank;
            load_done   <= 1'b1;
            if (load_begin) begin
              state   <= LOAD;
              ready_q <= 1'b1;
              idx     <= '0;
`ifdef FIR_COEFFS_CHECKSUM_EN
              sum     <= '0;
`endif
            end else begin
              state <= IDLE;
            end
          end else if (load_begin) begin
            state      <= LOAD;
            ready_q    <= 1'b1;
            load_error <= 1'b1;
            idx        <= '0;
`ifdef FIR_COEFFS_CHECKSUM_EN
            sum        <= '0;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeffs_loader.sv
// tb/tb_fir_coeffs_loader.sv - directed bench with a set-level reference model for fir_coeffs_loader
module tb_fir_coeffs_loader;
  localparam int N = 256;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        load_begin = 1'b0;
  logic        start = 1'b0;
  logic        ram_we;
  logic [8:0]  ram_addr;
  logic [23:0] ram_wdata;
  logic        active_bank;
  logic        load_done;
  logic        load_error;

  fir_coeffs_loader_if #(.COEFF_WIDTH(24)) wr_if ();

  fir_coeffs_loader #(.NUM_COEFFS(N), .ADDR_WIDTH(8), .COEFF_WIDTH(24)) dut (
    .clock(clock), .reset_n(reset_n), .load_begin(load_begin), .start(start),
    .wr(wr_if.slave), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .active_bank(active_bank), .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what phase the current set is in and what the outputs must be next cycle.
  typedef enum {M_IDLE, M_LOAD, M_CHECK, M_ARMED} mphase_t;
  mphase_t     mphase = M_IDLE;
  int          mcnt = 0;
  logic [23:0] msum = '0;
  logic        mbank = 1'b0;
  logic        e_ready = 1'b0, e_we = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [8:0]  e_addr = '0;
  logic [23:0] e_data = '0;
  logic        m_acc = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mphase = M_IDLE; mcnt = 0; msum = '0; mbank = 1'b0;
      e_ready = 1'b0; e_we = 1'b0; e_done = 1'b0; e_err = 1'b0; m_acc = 1'b0;
    end else begin
      m_acc  = wr_if.wr_valid && e_ready && !load_begin;
      e_we   = 1'b0;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (mphase == M_ARMED && start) begin
        mbank = ~mbank; e_done = 1'b1; mphase = M_IDLE; e_ready = 1'b0;
      end
      if (load_begin) begin
        if (mphase != M_IDLE) e_err = 1'b1;
        mphase = M_LOAD; mcnt = 0; msum = '0; e_ready = 1'b1;
      end else if (m_acc && mphase == M_LOAD) begin
        e_we = 1'b1; e_addr = {~mbank, 8'(mcnt)}; e_data = wr_if.wr_data;
        msum = msum + wr_if.wr_data;
        mcnt++;
        if (mcnt == N) begin
`ifdef FIR_COEFFS_CHECKSUM_EN
          mphase = M_CHECK;
`else
          mphase = M_ARMED; e_ready = 1'b0;
`endif
        end
      end else if (m_acc && mphase == M_CHECK) begin
        e_ready = 1'b0;
        if (wr_if.wr_data == msum) mphase = M_ARMED;
        else begin mphase = M_IDLE; e_err = 1'b1; end
      end
    end
  end

  logic [8:0]  wlog_addr[$];
  logic [23:0] wlog_data[$];

  always @(negedge clock) begin
    chk("wr_ready", wr_if.wr_ready, e_ready);
    chk("active_bank", active_bank, mbank);
    chk("load_done", load_done, e_done);
    chk("load_error", load_error, e_err);
    chk("ram_we", ram_we, e_we);
    if (e_we) begin
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_data);
    end
    if (ram_we) begin
      wlog_addr.push_back(ram_addr);
      wlog_data.push_back(ram_wdata);
    end
  end

  logic [23:0] drv_sum = '0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // kind 0: idx*3, kind 1: scrambled values, kind 2: constant cval (checksum word)
  task automatic send(input int n, input int gap, input int kind, input logic [23:0] cval);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 4000) begin
      wr_if.wr_valid = (gap == 0) || ($urandom_range(99) >= gap);
      wr_if.wr_data  = (kind == 0) ? 24'(k * 3) : (kind == 1) ? 24'(k * 40503 + 977) : cval;
      step();
      if (m_acc) begin
        if (kind != 2) drv_sum = drv_sum + wr_if.wr_data;
        k++;
      end
      guard++;
    end
    wr_if.wr_valid = 1'b0;
    if (guard >= 4000) chk("send_timeout", 32'(k), 32'(n));
  endtask

  task automatic arm();
`ifdef FIR_COEFFS_CHECKSUM_EN
    send(1, 0, 2, drv_sum);
`endif
  endtask

  task automatic pulse_load();
    load_begin = 1'b1; step(); load_begin = 1'b0; drv_sum = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ram_addr", ram_addr, 9'h000);
    chk("rst_ram_wdata", ram_wdata, 24'h0);
    chk("rst_active_bank", active_bank, 1'b0);
    chk("rst_wr_ready", wr_if.wr_ready, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    idle(2);

    // Full set of idx*3 with valid held high
    wlog_addr.delete(); wlog_data.delete();
    pulse_load();
    send(N, 0, 0, '0);
    arm();
    idle(3);
    chk("writes_full", 32'(wlog_addr.size()), 32'd256);
    chk("first_addr", wlog_addr[0], 9'h100);
    chk("last_addr", wlog_addr[255], 9'h1FF);
    chk("last_data", wlog_data[255], 24'd765);
    chk("bank_before_start", active_bank, 1'b0);
    pulse_start();
    chk("bank_after_start", active_bank, 1'b1);
    chk("done_after_start", load_done, 1'b1);
    idle(2);

    // 30% idle gaps on wr_valid
    wlog_addr.delete(); wlog_data.delete();
    pulse_load();
    send(N, 30, 1, '0);
    arm();
    idle(2);
    chk("writes_gappy", 32'(wlog_addr.size()), 32'd256);
    chk("gappy_first", wlog_addr[0], 9'h000);
    pulse_start();
    chk("bank_gappy", active_bank, 1'b0);

    // Abort after 100 words
    pulse_load();
    send(100, 0, 0, '0);
    pulse_load();
    chk("abort_error", load_error, 1'b1);
    chk("abort_bank", active_bank, 1'b0);
    wlog_addr.delete(); wlog_data.delete();
    send(N, 0, 0, '0);
    arm();
    idle(2);
    chk("abort_restart_addr", wlog_addr[0], 9'h100);
    chk("abort_writes", 32'(wlog_addr.size()), 32'd256);
    pulse_start();
    chk("bank_abort", active_bank, 1'b1);

    // start and load_begin together while armed
    pulse_load();
    send(N, 0, 0, '0);
    arm();
    idle(2);
    start = 1'b1; load_begin = 1'b1; step(); start = 1'b0; load_begin = 1'b0; drv_sum = '0;
    chk("both_bank", active_bank, 1'b0);
    chk("both_done", load_done, 1'b1);
    chk("both_error", load_error, 1'b0);
    wlog_addr.delete(); wlog_data.delete();
    send(5, 0, 0, '0);
    idle(1);
    chk("both_next_addr", wlog_addr[0], 9'h100);
    send(N - 5, 0, 1, '0);
    arm();
    idle(2);
    pulse_start();
    chk("both_final_bank", active_bank, 1'b1);

    // Reset while armed
    pulse_load();
    send(N, 0, 0, '0);
    arm();
    idle(2);
    reset_n = 1'b0;
    #1;
    chk("armrst_bank", active_bank, 1'b0);
    chk("armrst_ready", wr_if.wr_ready, 1'b0);
    step();
    reset_n = 1'b1;
    idle(1);
    pulse_start();
    chk("armrst_no_done", load_done, 1'b0);
    chk("armrst_no_swap", active_bank, 1'b0);
    idle(2);

`ifdef FIR_COEFFS_CHECKSUM_EN
    pulse_load();
    send(N, 0, 0, '0);
    send(1, 0, 2, drv_sum);
    idle(2);
    pulse_start();
    chk("cs_good_swap", active_bank, 1'b1);
    pulse_load();
    send(N, 0, 0, '0);
    send(1, 0, 2, drv_sum + 24'd1);
    chk("cs_bad_error", load_error, 1'b1);
    idle(1);
    pulse_start();
    chk("cs_bad_no_swap", active_bank, 1'b1);
    chk("cs_bad_no_done", load_done, 1'b0);
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
